// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_CNT_W = $clog2(MULDIV_WIDTH);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    // Counter width needed to hold WIDTH-1 for an arbitrary operand width.
    function automatic int muldiv_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per step, MSB first.
// Latency: WIDTH steps after load; quo/rem show the sign-corrected result of the step in flight.
// Backpressure: none; the owner decides when to load and when to step. Built only with MULDIV_DIV_EN.
`ifdef MULDIV_DIV_EN
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);
    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic             neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0] a_mag, b_mag, rem_n, quo_n;
    logic [WIDTH:0]   rem_sh, diff;

    // Magnitudes for load, one shift/subtract step, and sign fix-up of the step result.
    always_comb begin
        a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, div_q};
        if (!diff[WIDTH]) begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = rem_sh[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b0};
        end
        quo = neg_quo_q ? -quo_n : quo_n;
        rem = neg_rem_q ? -rem_n : rem_n;
    end

    // Dividend magnitude sits in the quotient register and shifts out as quotient bits shift in.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (load) begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            div_q     <= b_mag;
            neg_quo_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= sgn & a[WIDTH-1];
        end else if (step) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
        end
    end

endmodule
`endif

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: MULT/MULTU via a MUL_LAT-deep pipeline, DIV/DIVU iterative (MULDIV_DIV_EN).
// Latency: done sampled at accept+MUL_LAT+1 (mul), accept+WIDTH+1 (div), accept+1 (div by zero / no divider).
// Backpressure: start accepted only while ready (IDLE); busy stalls the pipe; flush cancels without done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = MULDIV_WIDTH,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int               CNT_W        = muldiv_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);

    muldiv_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_mul, mul_sgn, mul_load, res_we;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [2*WIDTH-1:0] mul_ax, mul_bx;
    logic [2*WIDTH-1:0] mul_pipe [MUL_LAT];

    assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    assign mul_sgn = (op == OP_MULT);
    assign mul_ax  = {{WIDTH{mul_sgn & a[WIDTH-1]}}, a};
    assign mul_bx  = {{WIDTH{mul_sgn & b[WIDTH-1]}}, b};

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q != ST_IDLE);

`ifdef MULDIV_DIV_EN
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(WIDTH - 1);
    logic             div_load, div_step;
    logic [WIDTH-1:0] div_quo, div_rem;

    muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk  (clk),
        .rst  (rst),
        .load (div_load),
        .step (div_step),
        .sgn  (op == OP_DIV),
        .a    (a),
        .b    (b),
        .quo  (div_quo),
        .rem  (div_rem)
    );
`endif

    // Next-state, counter and result-write decode; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_load = 1'b0;
        res_we   = 1'b0;
        res_hi   = '0;
        res_lo   = '0;
`ifdef MULDIV_DIV_EN
        div_load = 1'b0;
        div_step = 1'b0;
`endif
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            state_d  = ST_MUL;
                            cnt_d    = MUL_CNT_INIT;
                            mul_load = 1'b1;
                        end else begin
`ifdef MULDIV_DIV_EN
                            if (b == '0) begin
                                state_d = ST_DONE;
                                res_we  = 1'b1;
                                res_hi  = a;
                                res_lo  = '1;
                            end else begin
                                state_d  = ST_DIV;
                                cnt_d    = DIV_CNT_INIT;
                                div_load = 1'b1;
                            end
`else
                            state_d = ST_DONE;
                            res_we  = 1'b1;
`endif
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        state_d          = ST_DONE;
                        res_we           = 1'b1;
                        {res_hi, res_lo} = mul_pipe[MUL_LAT-1];
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    div_step = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        res_we  = 1'b1;
                        res_hi  = div_rem;
                        res_lo  = div_quo;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and iteration counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Product enters on accept and ripples one stage per cycle; the last stage feeds HI/LO.
    always_ff @(posedge clk) begin
        if (mul_load) begin
            mul_pipe[0] <= mul_ax * mul_bx;
        end
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    // HI/LO update only on entry to DONE; done is high for exactly the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state_d == ST_DONE);
            if (res_we) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule
